alu_opstage: RTL

Registered operand/decode stage directly upstream of the ALU shift unit and its sibling ALU units. Accepts one Beta ALU instruction per cycle (opcode, register operands, 16-bit literal) over a valid/ready handshake, selects and sign-extends the B operand, and decodes the opcode into a unit select, function code and shift control `sfn`. Results are held in a one-cycle output register backed by a one-entry skid buffer, so downstream back-pressure never creates a combinational ready path.

---
 rtl/alu_opstage.sv | 127 ++++++++++++
 1 files changed

// File: rtl/alu_opstage.sv
// alu_opstage: registered operand/decode stage ahead of the Beta ALU units.
// Selects and sign-extends operand B, decodes the opcode into unit/fn/sfn,
// and holds results in an output register backed by a one-entry skid buffer
// so in_ready never depends combinationally on out_ready.
module alu_opstage (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_op,
    input  logic [31:0] in_ra,
    input  logic [31:0] in_rb,
    input  logic [15:0] in_lit,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [2:0]  out_unit,
    output logic [3:0]  out_fn,
    output logic [1:0]  out_sfn,
    output logic        out_illegal
);

    typedef enum logic [2:0] {
        UNIT_ARITH   = 3'd0,
        UNIT_CMP     = 3'd1,
        UNIT_BOOL    = 3'd2,
        UNIT_SHIFT   = 3'd3,
        UNIT_MUL     = 3'd4,
        UNIT_ILLEGAL = 3'd7
    } unit_e;

    typedef enum logic [1:0] {
        SFN_SHL = 2'b00,
        SFN_SHR = 2'b01,
        SFN_SRA = 2'b11
    } sfn_e;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        unit_e       unit;
        logic [3:0]  fn;
        sfn_e        sfn;
        logic        illegal;
    } entry_t;

    entry_t dec;
    entry_t out_q;
    entry_t skid_q;
    logic   skid_valid;
    logic   accept;

    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready;

    // Decode the incoming instruction into the entry format held by both registers.
    always_comb begin
        // NOTE: every field gets a default first so no path leaves it unassigned
        // (an unassigned path in always_comb would infer a latch).
        dec.a       = in_ra;
        dec.b       = in_op[4] ? {{16{in_lit[15]}}, in_lit} : in_rb;
        dec.unit    = UNIT_ILLEGAL;
        dec.fn      = in_op[3:0];
        dec.sfn     = SFN_SHL;
        dec.illegal = 1'b1;
        if (in_op[5]) begin
            unique case (in_op[3:0])
                4'h0, 4'h1:             dec.unit = UNIT_ARITH;
                4'h2:                   dec.unit = UNIT_MUL;
                4'h4, 4'h5, 4'h6:       dec.unit = UNIT_CMP;
                4'h8, 4'h9, 4'hA, 4'hB: dec.unit = UNIT_BOOL;
                4'hC:                   dec.unit = UNIT_SHIFT;
                4'hD: begin
                    dec.unit = UNIT_SHIFT;
                    dec.sfn  = SFN_SHR;
                end
                4'hE: begin
                    dec.unit = UNIT_SHIFT;
                    dec.sfn  = SFN_SRA;
                end
                default:                dec.unit = UNIT_ILLEGAL; // DIV, 0x7, 0xF
            endcase
            dec.illegal = (dec.unit == UNIT_ILLEGAL);
        end
    end

    // Output register plus skid buffer; SKID always drains into OUT first to keep FIFO order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the data fields are reset too, because the outputs must read
            // zero during reset, not just the valid bits.
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || out_ready) begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values; blocking here would let SKID and OUT race.
            if (skid_valid) begin
                out_q      <= skid_q;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_q     <= dec;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
        end
    end

    assign out_a       = out_q.a;
    assign out_b       = out_q.b;
    assign out_unit    = out_q.unit;
    assign out_fn      = out_q.fn;
    assign out_sfn     = out_q.sfn;
    assign out_illegal = out_q.illegal;

endmodule
